sha256_msg_scheduler: RTL and testbench
=======================================

Name: sha256_msg_scheduler

Overview:
- Sequential producer side of the SHA-256 round datapath.
- Accepts one 512-bit padded message block per handshake and expands it into the 64-word schedule W[t].
- Each cycle it drives w_data and k_out plus the round/digest control strobes consumed by sha256_update_variables.
- Sits between the padder/block source and the compressor; owns all round sequencing for a block.

Parameters:
- NUM_ROUNDS, 64, rounds per block. Must be 64 for compliance; 17..64 permitted in simulation only.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- block_valid  in  1  block_data/first_block_in valid
- block_ready  out  1  scheduler can accept a block
- block_data  in  512  padded block; word 0 = bits [511:480], big-endian words
- first_block_in  in  1  block is first of message
- first_block  out  1  registered first_block_in, held for the whole block
- init_round  out  1  load A-H strobe
- init_digest  out  1  load H strobe
- partial_rounds  out  1  compression-round strobe
- update_digest  out  1  H += A..H strobe
- w_data  out  32  W[t] for current round
- k_out  out  32  K[t] for current round
- round_idx  out  6  current t (0..63)
- block_done  out  1  one-cycle pulse, block's digest update issued

Behaviour:
- Reset (async, any state): state=IDLE; block_ready=1; all other outputs 0; schedule window cleared; round counter 0.
- FSM states: IDLE -> INIT -> ROUND -> DIGEST -> IDLE.
- IDLE:
  - block_ready=1.
  - On block_valid&block_ready: latch the 16 words into window W[0..15] (W[0] = block_data[511:480]), latch first_block, go INIT.
- INIT (1 cycle): init_round=1 and init_digest=1; partial_rounds=0; block_ready=0; go ROUND with t=0.
- ROUND (NUM_ROUNDS cycles):
  - partial_rounds=1; w_data=window[0]; k_out=K[t]; round_idx=t.
  - Each cycle the window shifts left by one and window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - After t=NUM_ROUNDS-1 go DIGEST.
- DIGEST (1 cycle): update_digest=1; block_done=1; go IDLE. block_ready rises the following cycle.
- Strobe exclusivity: init_round, partial_rounds and update_digest are mutually exclusive every cycle. w_data and k_out are 0 outside ROUND.
- Latency: handshake at cycle 0 -> INIT cycle 1 -> rounds cycles 2..65 -> DIGEST cycle 66 -> block_ready=1 at cycle 67.
- Back-to-back: a block offered while busy is not accepted (block_ready=0). Source holds block_valid/data stable until accepted.
- Mid-block behaviour:
  - block_data/first_block_in changes after acceptance have no effect.
  - first_block output stays stable from INIT through DIGEST.
- Counter: t is 6-bit, compared to NUM_ROUNDS-1, no wrap use.
- Reset mid-block: the block is abandoned; no block_done, no update_digest. Next block restarts from IDLE.
- Outputs are registered from FSM/window state (no combinational path from block_valid to any output except none; block_ready depends on state only).

Decomposition:
- Shared package sha256_pkg:
  - K[0..63] constant array
  - H0 initial constants
  - FSM state enum
  - sigma0/sigma1 functions, also reused by the compressor's Sigma logic file set
- One natural sub-module: sha256_k_rom (6-bit index -> 32-bit K, combinational case table).
- Window and FSM stay in the top.

Test Plan:
- "abc" single block (0x61626380, 14 zero words, 0x00000018), first_block_in=1 -> w_data at t=0..3 = 0x61626380, 0, 0, 0; t=16..19 = 0x61626380, 0x000F0000, 0x7DA86405, 0x600003C6; k_out t=0 = 0x428A2F98, t=63 = 0xC67178F2.
- Strobe timing, same block -> exactly 1 init_round+init_digest cycle, 64 partial_rounds cycles, 1 update_digest/block_done cycle; block_ready low for exactly 66 cycles after acceptance.
- Back-to-back blocks with block_valid held high, second first_block_in=0 -> second accepted at cycle 67; first_block=0 throughout second block.
- Stimulus change: block_data and first_block_in changed mid-ROUND -> w_data sequence and first_block unchanged.
- Async reset asserted at t=30, released off-edge -> all outputs 0 immediately, block_ready=1 after release; no block_done; new "abc" block reproduces the golden W sequence.
- Full-message check against reference model: 2-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" run through the compressor -> final H0..H7 = 248D6A61 D20638B8 E5C02693 0C3E6039 A33CE459 64FF2167 F6ECEDD4 19DB06C1.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Purpose  : Shared SHA-256 constants, FSM state encodings and the small /
//            big sigma helper functions used by the scheduler and compressor.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int WIN_DEPTH = 16;
    localparam int BLOCK_W   = WORD_W * WIN_DEPTH;

    typedef logic [WORD_W-1:0] word_t;

    // Scheduler FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DIGEST = 2'd3;

    // Round constants K[0..63]
    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value H(0)
    localparam word_t H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule sigma functions
    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression-round Sigma functions
    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_scheduler_if
// Purpose  : Block handshake plus round/digest control bundle between the
//            block source, the message scheduler and the compressor.
//            master = block source / round consumer, slave = scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_msg_scheduler_if;
    import sha256_pkg::*;

    logic                block_valid;
    logic                block_ready;
    logic [BLOCK_W-1:0]  block_data;
    logic                first_block_in;
    logic                first_block;
    logic                init_round;
    logic                init_digest;
    logic                partial_rounds;
    logic                update_digest;
    word_t               w_data;
    word_t               k_out;
    logic [5:0]          round_idx;
    logic                block_done;

    modport master (
        output block_valid, block_data, first_block_in,
        input  block_ready, first_block, init_round, init_digest,
               partial_rounds, update_digest, w_data, k_out, round_idx,
               block_done
    );

    modport slave (
        input  block_valid, block_data, first_block_in,
        output block_ready, first_block, init_round, init_digest,
               partial_rounds, update_digest, w_data, k_out, round_idx,
               block_done
    );
endinterface
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
// Module   : sha256_k_rom
// Purpose  : Combinational 64-entry SHA-256 round-constant table.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_k_rom (
    input  wire  [5:0]  idx,
    output logic [31:0] k
);
    // Constant lookup; every index is covered so the default is never taken.
    always_comb begin
        k = 32'h0;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/sha256_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_scheduler
// Purpose  : Accepts one padded 512-bit block, expands it into W[0..63] with a
//            16-word sliding window and sequences the compressor strobes
//            (IDLE -> INIT -> ROUND x NUM_ROUNDS -> DIGEST -> IDLE).
//            NUM_ROUNDS must be 64 for a compliant digest; 17..64 is only
//            meaningful for shortened simulation runs.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_scheduler
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input wire               clk,
    input wire               rst,
    sha256_msg_scheduler_if.slave bus
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    logic [1:0] r_state;
    logic [5:0] r_round;
    logic       r_first;
    word_t      r_window [WIN_DEPTH];

    word_t      w_next_word;
    word_t      w_k;
    logic       w_accept;

    // The only input-dependent decision; outputs never see block_valid.
    assign w_accept = (r_state == ST_IDLE) && bus.block_valid;

    // Next schedule word W[t+16] from the current window W[t..t+15].
    assign w_next_word = sigma1(r_window[14]) + r_window[9]
                       + sigma0(r_window[1]) + r_window[0];

    sha256_k_rom u_k_rom (
        .idx (r_round),
        .k   (w_k)
    );

    // Block sequencing FSM and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_round <= 6'd0;
                    if (w_accept) begin
                        r_state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_round <= 6'd0;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (r_round == LAST_ROUND) begin
                        r_round <= 6'd0;
                        r_state <= ST_DIGEST;
                    end else begin
                        r_round <= r_round + 6'd1;
                    end
                end
                ST_DIGEST: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_round <= 6'd0;
                end
            endcase
        end
    end

    // Schedule window: loaded on acceptance, shifted once per round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                r_window[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                r_window[i] <= bus.block_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
        end else if (r_state == ST_ROUND) begin
            for (int i = 0; i < WIN_DEPTH-1; i++) begin
                r_window[i] <= r_window[i+1];
            end
            r_window[WIN_DEPTH-1] <= w_next_word;
        end
    end

    // first_block is captured with the block and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_first <= bus.first_block_in;
        end
    end

    // Output decode purely from registered state.
    assign bus.block_ready    = (r_state == ST_IDLE);
    assign bus.init_round     = (r_state == ST_INIT);
    assign bus.init_digest    = (r_state == ST_INIT);
    assign bus.partial_rounds = (r_state == ST_ROUND);
    assign bus.update_digest  = (r_state == ST_DIGEST);
    assign bus.block_done     = (r_state == ST_DIGEST);
    assign bus.first_block    = r_first;
    assign bus.w_data         = (r_state == ST_ROUND) ? r_window[0] : '0;
    assign bus.k_out          = (r_state == ST_ROUND) ? w_k : '0;
    assign bus.round_idx      = (r_state == ST_ROUND) ? r_round : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_scheduler
// Purpose  : Self-checking bench: golden "abc" schedule vectors, strobe and
//            latency checks, back-to-back blocks, mid-block stimulus change,
//            async reset mid-block, and a two-block digest via a behavioural
//            compressor fed by the scheduler outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    sha256_msg_scheduler_if bus ();

    sha256_msg_scheduler #(.NUM_ROUNDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- checks
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------------------------------------------------------- monitor
    logic [31:0] wlog [64];
    logic [31:0] klog [64];
    bit          wseen [64];
    int blk = -1;
    int acc_cyc [8], init_cyc [8], done_cyc [8];
    int n_init [8], n_rnd [8], n_dig [8], n_done [8], busy [8];
    bit fb_and [8], fb_or [8];
    int excl_bad = 0, zero_bad = 0, kbad = 0, idig_bad = 0;

    // behavioural compressor
    logic [31:0] hm [8];
    logic [31:0] st [8];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always @(negedge clk) begin
        int b;
        logic [31:0] t1, t2, e, a;
        if (!rst) begin
            if (bus.block_valid && bus.block_ready) begin
                blk = blk + 1;
                b = blk % 8;
                acc_cyc[b] = cyc; init_cyc[b] = -1; done_cyc[b] = -1;
                n_init[b] = 0; n_rnd[b] = 0; n_dig[b] = 0; n_done[b] = 0;
                busy[b] = 0; fb_and[b] = 1'b1; fb_or[b] = 1'b0;
                for (int i = 0; i < 64; i++) wseen[i] = 1'b0;
            end
            b = (blk < 0) ? 0 : blk % 8;
            if (!bus.block_ready) begin
                busy[b]++;
                fb_and[b] = fb_and[b] & bus.first_block;
                fb_or[b]  = fb_or[b]  | bus.first_block;
            end
            if ((int'(bus.init_round) + int'(bus.partial_rounds) + int'(bus.update_digest)) > 1)
                excl_bad++;
            if (!bus.partial_rounds && (bus.w_data != 32'h0 || bus.k_out != 32'h0))
                zero_bad++;
            if (bus.init_round != bus.init_digest) idig_bad++;
            if (bus.init_round) begin
                n_init[b]++;
                init_cyc[b] = cyc;
                if (bus.first_block)
                    for (int i = 0; i < 8; i++) hm[i] = sha256_pkg::H0[i];
                for (int i = 0; i < 8; i++) st[i] = hm[i];
            end
            if (bus.partial_rounds) begin
                n_rnd[b]++;
                wlog[bus.round_idx]  = bus.w_data;
                klog[bus.round_idx]  = bus.k_out;
                wseen[bus.round_idx] = 1'b1;
                if (bus.k_out != sha256_pkg::K[bus.round_idx]) kbad++;
                e = st[4]; a = st[0];
                t1 = st[7] + (rr(e,6) ^ rr(e,11) ^ rr(e,25)) + ((e & st[5]) ^ (~e & st[6]))
                   + bus.k_out + bus.w_data;
                t2 = (rr(a,2) ^ rr(a,13) ^ rr(a,22)) + ((a & st[1]) ^ (a & st[2]) ^ (st[1] & st[2]));
                for (int i = 7; i > 0; i--) st[i] = st[i-1];
                st[4] = st[4] + t1;
                st[0] = t1 + t2;
            end
            if (bus.update_digest) begin
                n_dig[b]++;
                for (int i = 0; i < 8; i++) hm[i] = hm[i] + st[i];
            end
            if (bus.block_done) begin
                n_done[b]++;
                done_cyc[b] = cyc;
            end
        end
    end

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int          t;
        bit          chk_w;
        logic [31:0] w;
        bit          chk_k;
        logic [31:0] k;
    } vec_t;

    vec_t vecs [9];

    localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] MSG1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG2 = {{15{32'h0}}, 32'h000001c0};

    logic [31:0] exp_abc [8];
    logic [31:0] exp_two [8];

    task automatic drive(input logic [511:0] d, input logic f, input logic v);
        bus.block_data     = d;
        bus.first_block_in = f;
        bus.block_valid    = v;
    endtask

    // block_valid must already be high; returns 1 ns after the accepting edge
    task automatic wait_accept(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.block_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        check({name, "_accept"}, 64'(got), 64'd1);
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.block_done) got = 1'b1;
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic check_abc_sched(input string name);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].chk_w)
                check($sformatf("%s_w%0d", name, vecs[i].t),
                      64'(wseen[vecs[i].t] ? wlog[vecs[i].t] : 32'hxxxxxxxx), 64'(vecs[i].w));
            if (vecs[i].chk_k)
                check($sformatf("%s_k%0d", name, vecs[i].t), 64'(klog[vecs[i].t]), 64'(vecs[i].k));
        end
    endtask

    task automatic check_digest(input string name, input logic [31:0] exp [8]);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_H%0d", name, i), 64'(hm[i]), 64'(exp[i]));
    endtask

    // watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- test
    initial begin
        int b0, b1, b2;
        vecs[0] = '{0,  1'b1, 32'h61626380, 1'b1, 32'h428A2F98};
        vecs[1] = '{1,  1'b1, 32'h00000000, 1'b0, 32'h0};
        vecs[2] = '{2,  1'b1, 32'h00000000, 1'b0, 32'h0};
        vecs[3] = '{3,  1'b1, 32'h00000000, 1'b0, 32'h0};
        vecs[4] = '{16, 1'b1, 32'h61626380, 1'b0, 32'h0};
        vecs[5] = '{17, 1'b1, 32'h000F0000, 1'b0, 32'h0};
        vecs[6] = '{18, 1'b1, 32'h7DA86405, 1'b0, 32'h0};
        vecs[7] = '{19, 1'b1, 32'h600003C6, 1'b0, 32'h0};
        vecs[8] = '{63, 1'b0, 32'h0,        1'b1, 32'hC67178F2};
        exp_abc = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        exp_two = '{32'h248D6A61, 32'hD20638B8, 32'hE5C02693, 32'h0C3E6039,
                    32'hA33CE459, 32'h64FF2167, 32'hF6ECEDD4, 32'h19DB06C1};

        drive('0, 1'b0, 1'b0);

        // reset state (checked while reset is still asserted)
        #22;
        check("reset_ready", 64'(bus.block_ready), 64'd1);
        check("reset_strobes", 64'({bus.init_round, bus.init_digest, bus.partial_rounds,
                                    bus.update_digest, bus.block_done, bus.first_block}), 64'd0);
        check("reset_buses", 64'({bus.w_data, bus.k_out} | 64'(bus.round_idx)), 64'd0);
        #5 rst = 1'b0;

        // ---- single "abc" block: golden schedule, strobes, latency
        @(posedge clk); #1;
        drive(ABC, 1'b1, 1'b1);
        wait_accept("abc");
        bus.block_valid = 1'b0;
        wait_done("abc");
        b0 = blk % 8;
        @(negedge clk);
        check("abc_ready_after", 64'(bus.block_ready), 64'd1);
        check_abc_sched("abc");
        check("abc_n_init", 64'(n_init[b0]), 64'd1);
        check("abc_n_rounds", 64'(n_rnd[b0]), 64'd64);
        check("abc_n_digest", 64'(n_dig[b0]), 64'd1);
        check("abc_n_done", 64'(n_done[b0]), 64'd1);
        check("abc_busy_cycles", 64'(busy[b0]), 64'd66);
        check("abc_init_latency", 64'(init_cyc[b0] - acc_cyc[b0]), 64'd1);
        check("abc_done_latency", 64'(done_cyc[b0] - acc_cyc[b0]), 64'd66);
        check("abc_first_block", 64'(fb_and[b0]), 64'd1);
        check_digest("abc", exp_abc);

        // ---- back-to-back two-block message with block_valid held high
        @(posedge clk); #1;
        drive(MSG1, 1'b1, 1'b1);
        wait_accept("b2b1");
        b1 = blk % 8;
        drive(MSG2, 1'b0, 1'b1);
        wait_accept("b2b2");
        b2 = blk % 8;
        bus.block_valid = 1'b0;
        wait_done("b2b");
        @(negedge clk);
        check("b2b_gap", 64'(acc_cyc[b2] - acc_cyc[b1]), 64'd67);
        check("b2b_first1", 64'(fb_and[b1]), 64'd1);
        check("b2b_first2", 64'(fb_or[b2]), 64'd0);
        check("b2b_rounds2", 64'(n_rnd[b2]), 64'd64);
        check_digest("two_block", exp_two);

        // ---- stimulus change after acceptance
        @(posedge clk); #1;
        drive(ABC, 1'b1, 1'b1);
        wait_accept("chg");
        bus.block_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.block_data     = {16{32'hDEADBEEF}};
        bus.first_block_in = 1'b0;
        wait_done("chg");
        b0 = blk % 8;
        @(negedge clk);
        check_abc_sched("chg");
        check("chg_first_and", 64'(fb_and[b0]), 64'd1);
        check("chg_first_out", 64'(bus.first_block), 64'd1);
        check_digest("chg", exp_abc);

        // ---- async reset at t=30
        @(posedge clk); #1;
        drive(ABC, 1'b1, 1'b1);
        wait_accept("rst");
        bus.block_valid = 1'b0;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (bus.partial_rounds && bus.round_idx == 6'd30) got = 1'b1;
            end
            check("rst_reach_t30", 64'(got), 64'd1);
        end
        b0 = blk % 8;
        #2 rst = 1'b1;
        #1;
        check("rst_async_strobes", 64'({bus.init_round, bus.init_digest, bus.partial_rounds,
                                        bus.update_digest, bus.block_done, bus.first_block}), 64'd0);
        check("rst_async_buses", 64'({bus.w_data, bus.k_out} | 64'(bus.round_idx)), 64'd0);
        check("rst_async_ready", 64'(bus.block_ready), 64'd1);
        @(negedge clk); #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ready_after", 64'(bus.block_ready), 64'd1);
        check("rst_no_done", 64'(n_done[b0]), 64'd0);
        check("rst_no_digest", 64'(n_dig[b0]), 64'd0);

        @(posedge clk); #1;
        drive(ABC, 1'b1, 1'b1);
        wait_accept("post");
        bus.block_valid = 1'b0;
        wait_done("post");
        b0 = blk % 8;
        @(negedge clk);
        check_abc_sched("post");
        check("post_rounds", 64'(n_rnd[b0]), 64'd64);
        check_digest("post", exp_abc);

        // ---- global invariants
        check("strobe_exclusive", 64'(excl_bad), 64'd0);
        check("zero_outside_round", 64'(zero_bad), 64'd0);
        check("init_digest_pairing", 64'(idig_bad), 64'd0);
        check("k_table_all_rounds", 64'(kbad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
